// File: rtl/inst_mem_responder_pkg.sv
// Shared widths, the zero/NOP instruction and the fetch-entry payload
// carried from the read pipeline through the output FIFO.
package inst_mem_responder_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_DATA_W = 32;

    localparam logic [INST_DATA_W-1:0] NOP_INST = '0;

    typedef struct packed {
        logic [INST_DATA_W-1:0] inst;
        logic [INST_ADDR_W-1:0] pc;
        logic                   err;
    } fetch_entry_t;

endpackage

// File: rtl/inst_mem_responder_fetch_fifo.sv
// Circular valid/ready FIFO of fetch entries with synchronous flush.
// Head is read straight from storage; storage is reset so the head reads zero.
module fetch_fifo
    import inst_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     buf_q [DEPTH];
    fetch_entry_t     buf_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop & (cnt_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                buf_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head  = buf_q[rd_ptr_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: accepts PC fetches, reads word memory through
// a LAT-deep pipeline into an output FIFO, and back-pressures via credits.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W     = INST_ADDR_W,
    parameter int unsigned DATA_W     = INST_DATA_W,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned LAT        = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic [ADDR_W-1:0]            pc,
    output logic                         stall,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_WORDS)-1:0] wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         inst_valid,
    output logic [DATA_W-1:0]            inst,
    output logic [ADDR_W-1:0]            inst_pc,
    output logic                         inst_err,
    input  logic                         dec_ready
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    logic [LAT-1:0] s_vld_q, s_vld_d;
    fetch_entry_t   s_ent_q [LAT];
    fetch_entry_t   s_ent_d [LAT];

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             stall_q, stall_d;

    logic             acc;
    logic             req_err;
    logic [IDX_W-1:0] rd_idx;
    logic             push;
    logic             pop;
    fetch_entry_t     fifo_head;
    logic [OCC_W-1:0] fifo_cnt;
    logic             fifo_empty;

    // Preload port; fetches in the same cycle see the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        acc     = ce & ~stall_q & ~flush;
        rd_idx  = pc[IDX_W+1:2];
        req_err = (pc[1:0] != 2'b00) || ((pc >> (IDX_W + 2)) != '0);
        push    = s_vld_q[LAT-1] & ~flush;
        pop     = ~fifo_empty & dec_ready;

        s_vld_d      = '0;
        s_vld_d[0]   = acc;
        s_ent_d[0]   = '{inst: req_err ? NOP_INST : mem_q[rd_idx], pc: pc, err: req_err};
        for (int unsigned i = 1; i < LAT; i++) begin
            s_vld_d[i] = s_vld_q[i-1];
            s_ent_d[i] = s_ent_q[i-1];
        end
        if (flush) begin
            s_vld_d = '0;
        end

        // Credits cover every request between acceptance and consumption.
        occ_d = occ_q + OCC_W'(acc) - OCC_W'(pop);
        if (flush) begin
            occ_d = '0;
        end
        stall_d = (occ_d >= OCC_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_vld_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                s_ent_q[i] <= '0;
            end
            occ_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            s_vld_q <= s_vld_d;
            s_ent_q <= s_ent_d;
            occ_q   <= occ_d;
            stall_q <= stall_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (s_ent_q[LAT-1]),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .count     (fifo_cnt),
        .empty     (fifo_empty)
    );

    // The credit scheme must never let a push land on a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && fifo_cnt == OCC_W'(FIFO_DEPTH)));

    assign stall      = stall_q;
    assign inst_valid = ~fifo_empty;
    assign inst       = fifo_head.inst;
    assign inst_pc    = fifo_head.pc;
    assign inst_err   = fifo_head.err;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: queue-based fetch model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_mem_responder;

    localparam int unsigned TB_LAT   = 2;
    localparam int unsigned TB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic [31:0] pc = '0;
    logic        stall;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        dec_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    inst_mem_responder dut (
        .clk        (clk),
        .rst        (rst_n),
        .ce         (ce),
        .pc         (pc),
        .stall      (stall),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_err   (inst_err),
        .dec_ready  (dec_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: outstanding requests wait in pipe_q until their due edge, then sit in fifo_q.
    typedef struct {
        int unsigned due;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } ment_t;

    ment_t       pipe_q[$];
    ment_t       fifo_q[$];
    logic [31:0] mm [1024];
    int unsigned ecnt = 0;
    int          m_occ;
    ment_t       m_ent;

    initial begin
        for (int i = 0; i < 1024; i++) mm[i] = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q.delete();
            fifo_q.delete();
            ecnt = 0;
        end else begin
            m_occ = pipe_q.size() + fifo_q.size();
            if (flush) begin
                pipe_q.delete();
                fifo_q.delete();
            end else begin
                if (dec_ready && fifo_q.size() > 0) void'(fifo_q.pop_front());
                while (pipe_q.size() > 0 && pipe_q[0].due == ecnt) fifo_q.push_back(pipe_q.pop_front());
                if (ce && m_occ < int'(TB_DEPTH)) begin
                    m_ent.due  = ecnt + TB_LAT;
                    m_ent.pc   = pc;
                    m_ent.err  = (pc[1:0] != 2'b00) || (pc[31:12] != 20'h0);
                    m_ent.inst = m_ent.err ? 32'h0 : mm[pc[11:2]];
                    pipe_q.push_back(m_ent);
                end
            end
            if (wr_en) mm[wr_addr] = wr_data;
            ecnt++;
        end
    end

    always @(negedge clk) begin
        chk("valid", 64'(inst_valid), 64'(fifo_q.size() > 0));
        chk("stall", 64'(stall), 64'((pipe_q.size() + fifo_q.size()) >= int'(TB_DEPTH)));
        if (fifo_q.size() > 0) begin
            chk("inst", 64'(inst), 64'(fifo_q[0].inst));
            chk("inst_pc", 64'(inst_pc), 64'(fifo_q[0].pc));
            chk("inst_err", 64'(inst_err), 64'(fifo_q[0].err));
        end
    end

    logic [31:0] got_inst[$];
    logic [31:0] got_pc[$];
    logic        got_err[$];

    task automatic clr_got();
        got_inst.delete();
        got_pc.delete();
        got_err.delete();
    endtask

    task automatic grab();
        got_inst.push_back(inst);
        got_pc.push_back(inst_pc);
        got_err.push_back(inst_err);
    endtask

    task automatic collect(input int n);
        repeat (n) begin
            if (inst_valid && dec_ready) grab();
            @(negedge clk);
        end
    endtask

    // Four fetches pc=0,4,8,C with decode always ready; checks latency and order.
    task automatic run_first4(input string tag);
        int first;
        first = -1;
        clr_got();
        dec_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ce = (i < 4);
            pc = 32'(i * 4);
            @(negedge clk);
            if (inst_valid && first < 0) first = i;
            if (inst_valid) grab();
        end
        ce = 1'b0;
        chk({tag, "_latency"}, 64'(first), 64'(2));
        chk({tag, "_count"}, 64'(got_inst.size()), 64'(4));
        if (got_inst.size() == 4) begin
            chk({tag, "_i0"}, 64'(got_inst[0]), 64'h11);
            chk({tag, "_i1"}, 64'(got_inst[1]), 64'h22);
            chk({tag, "_i2"}, 64'(got_inst[2]), 64'h33);
            chk({tag, "_i3"}, 64'(got_inst[3]), 64'h44);
            chk({tag, "_p3"}, 64'(got_pc[3]), 64'hC);
            chk({tag, "_e0"}, 64'(got_err[0]), 64'h0);
        end
    endtask

    initial begin
        int k;
        logic acc_now;

        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(inst_valid), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_inst", 64'(inst), 64'h0);
        chk("rst_pc", 64'(inst_pc), 64'h0);
        chk("rst_err", 64'(inst_err), 64'h0);
        rst_n = 1'b1;

        // Preload words 0..7 with 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_addr = 10'(i);
            wr_data = 32'((i + 1) * 32'h11);
            @(negedge clk);
        end
        wr_en = 1'b0;

        run_first4("basic");

        // Back-pressure: decode stalled, PC generator holds pc while stalled
        dec_ready = 1'b0;
        ce = 1'b1;
        k = 0;
        pc = 32'h10;
        repeat (10) begin
            acc_now = ce && !stall;
            @(negedge clk);
            if (acc_now) begin
                k++;
                pc = 32'h10 + 32'(k * 4);
            end
        end
        ce = 1'b0;
        chk("bp_accepted", 64'(k), 64'd4);
        chk("bp_stall", 64'(stall), 64'h1);
        clr_got();
        dec_ready = 1'b1;
        grab();
        @(negedge clk);
        chk("bp_stall_fall", 64'(stall), 64'h0);
        collect(8);
        chk("bp_count", 64'(got_inst.size()), 64'd4);
        if (got_inst.size() == 4) begin
            chk("bp_i0", 64'(got_inst[0]), 64'h55);
            chk("bp_i1", 64'(got_inst[1]), 64'h66);
            chk("bp_i2", 64'(got_inst[2]), 64'h77);
            chk("bp_i3", 64'(got_inst[3]), 64'h88);
            chk("bp_p0", 64'(got_pc[0]), 64'h10);
            chk("bp_p3", 64'(got_pc[3]), 64'h1C);
        end

        // Misaligned and out-of-range requests
        clr_got();
        ce = 1'b1;
        pc = 32'h2;
        @(negedge clk);
        pc = 32'h1000;
        @(negedge clk);
        ce = 1'b0;
        collect(8);
        chk("err_count", 64'(got_inst.size()), 64'd2);
        if (got_inst.size() == 2) begin
            chk("err0_inst", 64'(got_inst[0]), 64'h0);
            chk("err0_flag", 64'(got_err[0]), 64'h1);
            chk("err0_pc", 64'(got_pc[0]), 64'h2);
            chk("err1_inst", 64'(got_inst[1]), 64'h0);
            chk("err1_flag", 64'(got_err[1]), 64'h1);
            chk("err1_pc", 64'(got_pc[1]), 64'h1000);
        end

        // Flush with two entries buffered and two in the pipeline
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ce = 1'b1;
            pc = 32'(i * 4);
            @(negedge clk);
        end
        ce = 1'b0;
        chk("pre_flush_valid", 64'(inst_valid), 64'h1);
        chk("pre_flush_stall", 64'(stall), 64'h1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", 64'(inst_valid), 64'h0);
        chk("flush_stall", 64'(stall), 64'h0);
        clr_got();
        ce = 1'b1;
        pc = 32'h8;
        dec_ready = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        collect(8);
        chk("flush_count", 64'(got_inst.size()), 64'd1);
        if (got_inst.size() == 1) begin
            chk("flush_inst", 64'(got_inst[0]), 64'h33);
            chk("flush_pc", 64'(got_pc[0]), 64'h8);
        end

        // Write to word 5 in the same cycle as a fetch of it
        clr_got();
        ce = 1'b1;
        pc = 32'h14;
        wr_en = 1'b1;
        wr_addr = 10'd5;
        wr_data = 32'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        ce = 1'b0;
        collect(8);
        chk("wr_count", 64'(got_inst.size()), 64'd2);
        if (got_inst.size() == 2) begin
            chk("wr_old", 64'(got_inst[0]), 64'h66);
            chk("wr_new", 64'(got_inst[1]), 64'hAA);
        end

        // Asynchronous reset with fetches in flight
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ce = 1'b1;
            pc = 32'h10 + 32'(i * 4);
            @(negedge clk);
        end
        ce = 1'b0;
        chk("pre_rst_valid", 64'(inst_valid), 64'h1);
        chk("pre_rst_stall", 64'(stall), 64'h1);
        chk("pre_rst_pc", 64'(inst_pc), 64'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(inst_valid), 64'h0);
        chk("arst_stall", 64'(stall), 64'h0);
        chk("arst_pc", 64'(inst_pc), 64'h0);
        chk("arst_inst", 64'(inst), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_first4("post_rst");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
